// File: rtl/fetch_icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package fetch_icache_pkg;

    localparam int unsigned WORD_SIZE         = 16;
    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned ICACHE_NUM_LINES  = 8;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

endpackage

// File: rtl/fetch_icache_array.sv
// Valid/tag/data storage for the instruction cache; combinational read, one-word write.
module fetch_icache_array
    import fetch_icache_pkg::*;
#(
    parameter int unsigned WordSize  = WORD_SIZE,
    parameter int unsigned LineWords = ICACHE_LINE_WORDS,
    parameter int unsigned NumLines  = ICACHE_NUM_LINES,
    localparam int unsigned Ofs      = $clog2(LineWords),
    localparam int unsigned Idx      = $clog2(NumLines),
    localparam int unsigned TagW     = WordSize - Idx - Ofs
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Idx-1:0]      rd_index_i,
    input  logic [Ofs-1:0]      rd_offset_i,
    output logic                rd_valid_o,
    output logic [TagW-1:0]     rd_tag_o,
    output logic [WordSize-1:0] rd_data_o,
    input  logic                wr_en_i,
    input  logic [Idx-1:0]      wr_index_i,
    input  logic [Ofs-1:0]      wr_offset_i,
    input  logic [WordSize-1:0] wr_data_i,
    input  logic                set_valid_i,
    input  logic [TagW-1:0]     set_tag_i,
    input  logic                clr_valid_i,
    input  logic [Idx-1:0]      clr_index_i,
    input  logic                clear_all_i
);

    logic [NumLines-1:0] valid_q, valid_d;
    logic [TagW-1:0]     tag_mem  [NumLines];
    logic [WordSize-1:0] data_mem [NumLines][LineWords];

    // Valid-bit update; clear-all overrides any per-line set/clear.
    always_comb begin
        valid_d = valid_q;
        if (clr_valid_i) valid_d[clr_index_i] = 1'b0;
        if (set_valid_i) valid_d[wr_index_i] = 1'b1;
        if (clear_all_i) valid_d = '0;
    end

    // Only the valid bits are reset; tag/data contents are don't-care until validated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) valid_q <= '0;
        else         valid_q <= valid_d;
    end

    // Tag and data storage writes.
    always_ff @(posedge clk_i) begin
        if (wr_en_i)     data_mem[wr_index_i][wr_offset_i] <= wr_data_i;
        if (set_valid_i) tag_mem[wr_index_i] <= set_tag_i;
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[rd_index_i][rd_offset_i];

endmodule

// File: rtl/fetch_icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line fills on miss.
module fetch_icache #(
    parameter int unsigned WORD_SIZE  = fetch_icache_pkg::WORD_SIZE,
    parameter int unsigned LINE_WORDS = fetch_icache_pkg::ICACHE_LINE_WORDS,
    parameter int unsigned NUM_LINES  = fetch_icache_pkg::ICACHE_NUM_LINES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic [WORD_SIZE-1:0] cpu_address,
    output logic [WORD_SIZE-1:0] cpu_data,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ack,
    output logic [WORD_SIZE-1:0] num_access,
    output logic [WORD_SIZE-1:0] num_miss
);
    import fetch_icache_pkg::state_e;
    import fetch_icache_pkg::StIdle;
    import fetch_icache_pkg::StFill;

    localparam int unsigned OFS = $clog2(LINE_WORDS);
    localparam int unsigned IDX = $clog2(NUM_LINES);
    localparam int unsigned TAG = WORD_SIZE - IDX - OFS;

    logic [OFS-1:0] cpu_ofs;
    logic [IDX-1:0] cpu_idx;
    logic [TAG-1:0] cpu_tag;
    assign {cpu_tag, cpu_idx, cpu_ofs} = cpu_address;

    state_e               state_q, state_d;
    logic [OFS-1:0]       k_q, k_d;
    logic [TAG-1:0]       fill_tag_q, fill_tag_d;
    logic [IDX-1:0]       fill_index_q, fill_index_d;
    logic [WORD_SIZE-1:0] num_access_q, num_access_d;
    logic [WORD_SIZE-1:0] num_miss_q, num_miss_d;

    logic                 rd_valid;
    logic [TAG-1:0]       rd_tag;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 hit;
    logic                 wr_en, set_valid, clr_valid, clear_all;

    fetch_icache_array #(
        .WordSize  (WORD_SIZE),
        .LineWords (LINE_WORDS),
        .NumLines  (NUM_LINES)
    ) u_array (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .rd_index_i  (cpu_idx),
        .rd_offset_i (cpu_ofs),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_index_i  (fill_index_q),
        .wr_offset_i (k_q),
        .wr_data_i   (mem_data),
        .set_valid_i (set_valid),
        .set_tag_i   (fill_tag_q),
        .clr_valid_i (clr_valid),
        .clr_index_i (cpu_idx),
        .clear_all_i (clear_all)
    );

    // Lookup, fill sequencing, flush handling and counter next-state.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        fill_tag_d   = fill_tag_q;
        fill_index_d = fill_index_q;
        num_miss_d   = num_miss_q;
        wr_en        = 1'b0;
        set_valid    = 1'b0;
        clr_valid    = 1'b0;
        clear_all    = 1'b0;

        hit          = (state_q == StIdle) && cpu_read && rd_valid && (rd_tag == cpu_tag);
        cpu_ready    = hit;
        cpu_data     = hit ? rd_data : '0;
        num_access_d = num_access_q + WORD_SIZE'(hit);

        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    // Flush beats a coincident miss; the miss simply recurs next cycle.
                    clear_all = 1'b1;
                end else if (cpu_read && !hit) begin
                    fill_tag_d   = cpu_tag;
                    fill_index_d = cpu_idx;
                    clr_valid    = 1'b1;
                    k_d          = '0;
                    num_miss_d   = num_miss_q + WORD_SIZE'(1);
                    state_d      = StFill;
                end
            end
            StFill: begin
                if (flush) begin
                    // Abort: any ack this cycle is dropped and the line stays invalid.
                    clear_all = 1'b1;
                    k_d       = '0;
                    state_d   = StIdle;
                end else if (mem_ack) begin
                    wr_en = 1'b1;
                    if (k_q == OFS'(LINE_WORDS - 1)) begin
                        set_valid = 1'b1;
                        k_d       = '0;
                        state_d   = StIdle;
                    end else begin
                        k_d = k_q + OFS'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, fill registers and counters; reset abandons any fill in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            k_q          <= '0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
            num_access_q <= '0;
            num_miss_q   <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fill_tag_q   <= fill_tag_d;
            fill_index_q <= fill_index_d;
            num_access_q <= num_access_d;
            num_miss_q   <= num_miss_d;
        end
    end

    // Request is a pure function of registered state, so it is glitch-free.
    assign mem_read    = (state_q == StFill);
    assign mem_address = {fill_tag_q, fill_index_q, k_q};
    assign num_access  = num_access_q;
    assign num_miss    = num_miss_q;

endmodule

// File: tb/tb_fetch_icache.sv
// Self-checking bench for fetch_icache against a line-level cache model.
module tb_fetch_icache;

    logic        clk = 1'b0;
    logic        reset_n, cpu_read, flush, mem_ack;
    logic [15:0] cpu_address, mem_data;
    logic [15:0] cpu_data, mem_address, num_access, num_miss;
    logic        cpu_ready, mem_read;

    fetch_icache dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_read    (cpu_read),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .flush       (flush),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .num_access  (num_access),
        .num_miss    (num_miss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 8 lines of 4 words, tag = addr[15:5], index = addr[4:2].
    logic        m_valid [8];
    logic [10:0] m_tag   [8];
    int          exp_access, exp_miss;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return m_valid[a[4:2]] && (m_tag[a[4:2]] == a[15:5]);
    endfunction

    task automatic model_fill(input logic [15:0] a);
        m_valid[a[4:2]] = 1'b1;
        m_tag[a[4:2]]   = a[15:5];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // Memory responder: fixed latency, random latency, or ack tied high.
    bit          ack_high = 1'b0;
    bit          ack_rand = 1'b0;
    int          ack_lat  = 2;
    int          wait_cnt = 0;
    int          cur_lat  = 0;
    bit          req_new  = 1'b1;
    logic [15:0] cur_addr = '0;

    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
    end

    always @(posedge clk) begin
        #1;
        if (ack_high) begin
            mem_ack = 1'b1;
            req_new = 1'b1;
        end else if (mem_read !== 1'b1) begin
            mem_ack = 1'b0;
            req_new = 1'b1;
        end else begin
            if (req_new || mem_ack || mem_address != cur_addr) begin
                cur_addr = mem_address;
                wait_cnt = 0;
                cur_lat  = ack_rand ? int'($urandom_range(0, 3)) : ack_lat;
            end else begin
                wait_cnt++;
            end
            req_new = 1'b0;
            mem_ack = (wait_cnt >= cur_lat);
        end
        mem_data = mem_ack ? mem_word(mem_address) : 16'($urandom);
    end

    // Words the cache should be consuming, and cycles spent requesting.
    logic [15:0] acc_q[$];
    int          rd_cycles = 0;

    always @(posedge clk) begin
        if (reset_n && mem_read && mem_ack && !flush) acc_q.push_back(mem_address);
    end

    always @(negedge clk) begin
        if (mem_read === 1'b1) rd_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cpu_read = 1'b0;
        flush    = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        exp_access = 0;
        exp_miss   = 0;
    endtask

    // Present a fetch and hold it until satisfied; cyc counts cycles from first presentation.
    task automatic do_fetch(input logic [15:0] a, output int cyc, output logic [15:0] d,
                            output logic mr);
        cpu_address = a;
        cpu_read    = 1'b1;
        cyc = 0;
        d   = 'x;
        mr  = 1'bx;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                d  = cpu_data;
                mr = mem_read;
                break;
            end
            if (cyc >= 300) begin
                cyc = -1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        tick();
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0; cpu_read = 1'b1; cpu_address = 16'h0000; flush = 1'b0;
        ack_high = 0; ack_rand = 0; ack_lat = 2;
        model_clear();
        repeat (2) @(negedge clk);
        checks++; if (cpu_ready !== 1'b0 || cpu_data !== 16'h0) begin errors++;
            $display("FAIL reset_cpu: ready=%b data=%h want 0/0000", cpu_ready, cpu_data); end
        checks++; if (mem_read !== 1'b0 || mem_address !== 16'h0) begin errors++;
            $display("FAIL reset_mem: read=%b addr=%h want 0/0000", mem_read, mem_address); end
        checks++; if (num_access !== 16'h0 || num_miss !== 16'h0) begin errors++;
            $display("FAIL reset_cnt: access=%0d miss=%0d want 0/0", num_access, num_miss); end
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        checks++; if (cpu_ready !== 1'b0) begin errors++;
            $display("FAIL reset_first_miss: ready=%b want 0", cpu_ready); end
        @(negedge clk);
        checks++; if (mem_read !== 1'b1 || num_miss !== 16'd1 || mem_address !== 16'h0) begin
            errors++; $display("FAIL reset_fill_start: read=%b miss=%0d addr=%h want 1/1/0000",
                               mem_read, num_miss, mem_address); end
        n = 0;
        while (cpu_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (cpu_ready !== 1'b1 || cpu_data !== mem_word(16'h0)) begin errors++;
            $display("FAIL reset_fill_hit: ready=%b data=%h want 1/%h", cpu_ready, cpu_data,
                     mem_word(16'h0)); end
        tick();
        cpu_read = 1'b0;
    endtask

    task automatic test_cold_miss();
        int cyc; logic [15:0] d; logic mr; bit ok;
        apply_reset();
        ack_lat = 2;
        acc_q.delete();
        do_fetch(16'h0010, cyc, d, mr);
        model_fill(16'h0010); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h0010)) begin errors++;
            $display("FAIL cold_latency: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h0010)); end
        ok = (acc_q.size() == 4);
        for (int i = 0; i < 4; i++) if (ok && acc_q[i] !== 16'(16'h0010 + i)) ok = 0;
        checks++; if (!ok) begin errors++;
            $display("FAIL cold_addr_seq: got %0d words first=%h want 4 words 0010..0013",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 16'hxxxx); end
        checks++; if (num_access !== 16'(exp_access) || num_miss !== 16'(exp_miss)) begin
            errors++; $display("FAIL cold_counters: access=%0d miss=%0d want %0d/%0d",
                               num_access, num_miss, exp_access, exp_miss); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [15:0] d; logic mr; logic [15:0] a;
        for (int i = 1; i < 4; i++) begin
            a = 16'(16'h0010 + i);
            do_fetch(a, cyc, d, mr);
            exp_access++;
            checks++; if (cyc != 0 || d !== mem_word(a)) begin errors++;
                $display("FAIL b2b_hit %h: cycles=%0d data=%h want 0/%h", a, cyc, d,
                         mem_word(a)); end
            checks++; if (mr !== 1'b0) begin errors++;
                $display("FAIL b2b_mem_idle %h: mem_read=%b want 0", a, mr); end
        end
        cpu_read = 1'b0;
        checks++; if (num_access !== 16'd4 || num_miss !== 16'd1) begin errors++;
            $display("FAIL b2b_counters: access=%0d miss=%0d want 4/1", num_access, num_miss); end
    endtask

    task automatic test_conflict();
        int cyc; logic [15:0] d; logic mr; bit ok;
        acc_q.delete();
        do_fetch(16'h0030, cyc, d, mr);
        model_fill(16'h0030); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h0030)) begin errors++;
            $display("FAIL conflict_fill: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h0030)); end
        ok = (acc_q.size() == 4);
        for (int i = 0; i < 4; i++) if (ok && acc_q[i] !== 16'(16'h0030 + i)) ok = 0;
        checks++; if (!ok) begin errors++;
            $display("FAIL conflict_addr_seq: got %0d words want 0030..0033", acc_q.size()); end
        do_fetch(16'h0010, cyc, d, mr);
        model_fill(16'h0010); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h0010)) begin errors++;
            $display("FAIL conflict_refill: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h0010)); end
        cpu_read = 1'b0;
        checks++; if (num_miss !== 16'd3) begin errors++;
            $display("FAIL conflict_miss_cnt: miss=%0d want 3", num_miss); end
    endtask

    task automatic test_ack_high();
        int cyc; logic [15:0] d; logic mr; bit ok;
        ack_high = 1'b1;
        tick(); tick();
        acc_q.delete();
        rd_cycles = 0;
        do_fetch(16'h0004, cyc, d, mr);
        model_fill(16'h0004); exp_miss++; exp_access++;
        checks++; if (cyc != 5 || d !== mem_word(16'h0004)) begin errors++;
            $display("FAIL ackhigh_latency: cycles=%0d data=%h want 5/%h", cyc, d,
                     mem_word(16'h0004)); end
        checks++; if (rd_cycles != 4) begin errors++;
            $display("FAIL ackhigh_read_cycles: got %0d want 4", rd_cycles); end
        ok = (acc_q.size() == 4);
        for (int i = 0; i < 4; i++) if (ok && acc_q[i] !== 16'(16'h0004 + i)) ok = 0;
        checks++; if (!ok) begin errors++;
            $display("FAIL ackhigh_addr_seq: got %0d words want 0004..0007", acc_q.size()); end
        cpu_read = 1'b0;
        tick(); tick();
        checks++; if (num_access !== 16'(exp_access) || num_miss !== 16'(exp_miss)) begin
            errors++; $display("FAIL ackhigh_idle_ack: access=%0d miss=%0d want %0d/%0d",
                               num_access, num_miss, exp_access, exp_miss); end
        ack_high = 1'b0;
    endtask

    task automatic test_random();
        int cyc; logic [15:0] d; logic mr; logic [15:0] a; bit exp_hit, ok;
        ack_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = 16'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            exp_hit = model_hit(a);
            do_fetch(a, cyc, d, mr);
            ok = exp_hit ? (cyc == 0) : (cyc >= 5);
            checks++; if (!ok) begin errors++;
                $display("FAIL rand_timing %h: cycles=%0d want %s", a, cyc,
                         exp_hit ? "hit(0)" : "miss(>=5)"); end
            checks++; if (d !== mem_word(a)) begin errors++;
                $display("FAIL rand_data %h: got %h want %h", a, d, mem_word(a)); end
            if (!exp_hit) begin model_fill(a); exp_miss++; end
            exp_access++;
            if ($urandom_range(0, 3) == 0) begin cpu_read = 1'b0; tick(); end
        end
        cpu_read = 1'b0;
        checks++; if (num_access !== 16'(exp_access) || num_miss !== 16'(exp_miss)) begin
            errors++; $display("FAIL rand_counters: access=%0d miss=%0d want %0d/%0d",
                               num_access, num_miss, exp_access, exp_miss); end
        ack_rand = 1'b0;
        ack_lat  = 2;
    endtask

    task automatic test_flush();
        int cyc, n; logic [15:0] d; logic mr;
        // Flush during a hit: this cycle still hits, the line is gone afterwards.
        do_fetch(16'h0050, cyc, d, mr);
        if (!model_hit(16'h0050)) begin model_fill(16'h0050); exp_miss++; end
        exp_access++;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (cpu_ready !== 1'b1 || cpu_data !== mem_word(16'h0050)) begin errors++;
            $display("FAIL flush_idle_hit: ready=%b data=%h want 1/%h", cpu_ready, cpu_data,
                     mem_word(16'h0050)); end
        tick();
        flush = 1'b0; exp_access++; model_clear();
        do_fetch(16'h0050, cyc, d, mr);
        model_fill(16'h0050); exp_miss++; exp_access++;
        checks++; if (cyc < 5 || d !== mem_word(16'h0050)) begin errors++;
            $display("FAIL flush_idle_refill: cycles=%0d data=%h want >=5/%h", cyc, d,
                     mem_word(16'h0050)); end
        // Flush coincident with a miss: no fill starts, the miss recurs.
        cpu_address = 16'h7F00; cpu_read = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; cpu_read = 1'b0; model_clear();
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || num_miss !== 16'(exp_miss)) begin errors++;
            $display("FAIL flush_vs_miss: read=%b miss=%0d want 0/%0d", mem_read, num_miss,
                     exp_miss); end
        tick();
        do_fetch(16'h7F00, cyc, d, mr);
        model_fill(16'h7F00); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h7F00)) begin errors++;
            $display("FAIL flush_miss_recur: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h7F00)); end
        // Flush on the ack of the second fill word.
        acc_q.delete();
        cpu_address = 16'h0120; cpu_read = 1'b1; exp_miss++;
        n = 0;
        while (!(acc_q.size() == 1 && mem_ack === 1'b1) && n < 100) begin
            @(negedge clk); n++;
        end
        flush = 1'b1; cpu_read = 1'b0;
        tick();
        flush = 1'b0; model_clear();
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || cpu_ready !== 1'b0) begin errors++;
            $display("FAIL flush_fill_abort: read=%b ready=%b want 0/0", mem_read, cpu_ready); end
        tick();
        do_fetch(16'h0120, cyc, d, mr);
        model_fill(16'h0120); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h0120)) begin errors++;
            $display("FAIL flush_aborted_line: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h0120)); end
        do_fetch(16'h7F00, cyc, d, mr);
        model_fill(16'h7F00); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h7F00)) begin errors++;
            $display("FAIL flush_prior_line: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h7F00)); end
        cpu_read = 1'b0;
        checks++; if (num_access !== 16'(exp_access) || num_miss !== 16'(exp_miss)) begin
            errors++; $display("FAIL flush_counters: access=%0d miss=%0d want %0d/%0d",
                               num_access, num_miss, exp_access, exp_miss); end
    endtask

    task automatic test_reset_mid_fill();
        int cyc, n; logic [15:0] d; logic mr;
        acc_q.delete();
        cpu_address = 16'h0200; cpu_read = 1'b1;
        n = 0;
        while (acc_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
        reset_n = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0 || cpu_ready !== 1'b0) begin errors++;
            $display("FAIL rstfill_async: read=%b ready=%b want 0/0", mem_read, cpu_ready); end
        checks++; if (num_access !== 16'h0 || num_miss !== 16'h0) begin errors++;
            $display("FAIL rstfill_cnt: access=%0d miss=%0d want 0/0", num_access, num_miss); end
        cpu_read = 1'b0;
        tick();
        reset_n = 1'b1; model_clear(); exp_access = 0; exp_miss = 0;
        tick();
        do_fetch(16'h0200, cyc, d, mr);
        model_fill(16'h0200); exp_miss++; exp_access++;
        checks++; if (cyc != 13 || d !== mem_word(16'h0200)) begin errors++;
            $display("FAIL rstfill_refetch: cycles=%0d data=%h want 13/%h", cyc, d,
                     mem_word(16'h0200)); end
        cpu_read = 1'b0;
        checks++; if (num_access !== 16'(exp_access) || num_miss !== 16'(exp_miss)) begin
            errors++; $display("FAIL rstfill_counters: access=%0d miss=%0d want %0d/%0d",
                               num_access, num_miss, exp_access, exp_miss); end
    endtask

    initial begin
        reset_n = 1'b0; cpu_read = 1'b0; flush = 1'b0; cpu_address = '0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_ack_high();
        test_random();
        test_flush();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
